// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// MDU op codes and the MDU sequencer state type.
package pipe_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EXE  = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [1:0] MDU_NONE = 2'b00;
    localparam logic [1:0] MDU_MUL  = 2'b01;
    localparam logic [1:0] MDU_DIV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// Multi-cycle MDU sequencer: launches a mult/div when ID is not stalled and
// counts its latency, with a one-cycle DONE state in which HI/LO are written.
module mdu_seq
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic       stall,
    output logic       mdu_start,
    output logic       mdu_busy,
    output mdu_state_t state
);

    localparam int CW = $clog2(max2(MUL_LAT, DIV_LAT)) + 1;

    logic [CW-1:0] cnt;
    mdu_state_t    state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (mdu_start)
                cnt <= (op == MDU_MUL) ? CW'(MUL_LAT - 1) : CW'(DIV_LAT - 1);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (mdu_start) state_nxt = (op == MDU_MUL) ? ST_MUL : ST_DIV;
            ST_MUL,
            ST_DIV:  if (cnt == '0) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Op code 11 is reserved and never launches the unit.
    always_comb begin
        mdu_start = (state == ST_IDLE) && (op == MDU_MUL || op == MDU_DIV) && !stall;
        mdu_busy  = (state != ST_IDLE);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/forward controller for the 5-stage pipeline.
// Build option: define FORWARD_EN to enable the EXE/MEM forwarding network.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [1:0] id_mdu_op,
    input  logic       id_reads_hilo,
    input  logic       exe_rf_we,
    input  logic [4:0] exe_rf_waddr,
    input  logic       exe_is_load,
    input  logic       mem_rf_we,
    input  logic [4:0] mem_rf_waddr,
    output logic       pc_we,
    output logic       ii_we,
    output logic       ie_we,
    output logic       ie_bubble,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       mdu_start,
    output logic       mdu_busy
);

    logic       exe_a, exe_b, mem_a, mem_b;
    logic       raw_exe, raw_mem, load_use, mdu_hold, stall;
    mdu_state_t mdu_state;

    // $0 is hardwired, so a write to it never creates a dependency.
    assign exe_a = id_uses_rs && exe_rf_we && (exe_rf_waddr != 5'd0) && (exe_rf_waddr == id_rs_addr);
    assign exe_b = id_uses_rt && exe_rf_we && (exe_rf_waddr != 5'd0) && (exe_rf_waddr == id_rt_addr);
    assign mem_a = id_uses_rs && mem_rf_we && (mem_rf_waddr != 5'd0) && (mem_rf_waddr == id_rs_addr);
    assign mem_b = id_uses_rt && mem_rf_we && (mem_rf_waddr != 5'd0) && (mem_rf_waddr == id_rt_addr);

    assign raw_exe  = exe_a || exe_b;
    assign raw_mem  = mem_a || mem_b;
    assign load_use = raw_exe && exe_is_load;
    assign mdu_hold = (mdu_state != ST_IDLE) && (id_reads_hilo || id_mdu_op != MDU_NONE);

`ifdef FORWARD_EN
    assign stall     = load_use || mdu_hold;
    assign fwd_a_sel = exe_a ? FWD_EXE : (mem_a ? FWD_MEM : FWD_RF);
    assign fwd_b_sel = exe_b ? FWD_EXE : (mem_b ? FWD_MEM : FWD_RF);
`else
    // Without forwarding, ID waits until the writer reaches WB (write-before-read).
    assign stall     = raw_exe || raw_mem || mdu_hold;
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

    assign pc_we     = !stall;
    assign ii_we     = !stall;
    assign ie_we     = 1'b1;
    assign ie_bubble = stall;

    mdu_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu (
        .clk       (clk),
        .reset     (reset),
        .op        (id_mdu_op),
        .stall     (stall),
        .mdu_start (mdu_start),
        .mdu_busy  (mdu_busy),
        .state     (mdu_state)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow FORWARD_EN if defined.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

`ifdef FORWARD_EN
    localparam bit FW = 1'b1;
`else
    localparam bit FW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs_addr, id_rt_addr, exe_rf_waddr, mem_rf_waddr;
    logic       id_uses_rs, id_uses_rt, id_reads_hilo;
    logic [1:0] id_mdu_op;
    logic       exe_rf_we, exe_is_load, mem_rf_we;
    logic       pc_we, ii_we, ie_we, ie_bubble, mdu_start, mdu_busy;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    typedef struct {
        logic       stall;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       bs;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32)) u_dut (
        .clk(clk), .reset(reset),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_mdu_op(id_mdu_op), .id_reads_hilo(id_reads_hilo),
        .exe_rf_we(exe_rf_we), .exe_rf_waddr(exe_rf_waddr), .exe_is_load(exe_is_load),
        .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
        .pc_we(pc_we), .ii_we(ii_we), .ie_we(ie_we), .ie_bubble(ie_bubble),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mdu_start(mdu_start), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, expv);
        end
    endtask

    task automatic idle_in();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_mdu_op = MDU_NONE; id_reads_hilo = 1'b0;
        exe_rf_we = 1'b0; exe_rf_waddr = 5'd0; exe_is_load = 1'b0;
        mem_rf_we = 1'b0; mem_rf_waddr = 5'd0;
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic step(input logic stall, input logic [1:0] fa, input logic [1:0] fb,
                        input logic st, input logic bs, input string tag);
        exp_t e;
        q.push_back('{stall, fa, fb, st, bs, tag});
        @(negedge clk);
        e = q.pop_front();
        cmp({e.tag, ".pc_we"},     {1'b0, pc_we},     {1'b0, !e.stall});
        cmp({e.tag, ".ii_we"},     {1'b0, ii_we},     {1'b0, !e.stall});
        cmp({e.tag, ".ie_we"},     {1'b0, ie_we},     2'b01);
        cmp({e.tag, ".ie_bubble"}, {1'b0, ie_bubble}, {1'b0, e.stall});
        cmp({e.tag, ".fwd_a"},     fwd_a_sel,         e.fa);
        cmp({e.tag, ".fwd_b"},     fwd_b_sel,         e.fb);
        cmp({e.tag, ".start"},     {1'b0, mdu_start}, {1'b0, e.st});
        cmp({e.tag, ".busy"},      {1'b0, mdu_busy},  {1'b0, e.bs});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_in();
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "reset");
        reset = 1'b0;
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "idle");

        // lw $1 in EXE, add reads $1 in ID
        id_uses_rs = 1'b1; id_rs_addr = 5'd1;
        exe_rf_we = 1'b1; exe_rf_waddr = 5'd1; exe_is_load = 1'b1;
        step(1'b1, FW ? FWD_EXE : FWD_RF, 2'b00, 1'b0, 1'b0, "lu_stall");
        exe_rf_we = 1'b0; exe_is_load = 1'b0; mem_rf_we = 1'b1; mem_rf_waddr = 5'd1;
        step(!FW, FW ? FWD_MEM : FWD_RF, 2'b00, 1'b0, 1'b0, "lu_mem");
        idle_in();
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "lu_clear");

        // $2 written in both EXE and MEM; rs also names $2 but is unused
        id_uses_rt = 1'b1; id_rt_addr = 5'd2; id_rs_addr = 5'd2;
        exe_rf_we = 1'b1; exe_rf_waddr = 5'd2; mem_rf_we = 1'b1; mem_rf_waddr = 5'd2;
        step(!FW, 2'b00, FW ? FWD_EXE : FWD_RF, 1'b0, 1'b0, "both_stage");
        exe_rf_we = 1'b0;
        step(!FW, 2'b00, FW ? FWD_MEM : FWD_RF, 1'b0, 1'b0, "mem_only");
        idle_in();
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "raw_clear");

        // $0 is never a hazard
        id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        exe_rf_we = 1'b1; exe_is_load = 1'b1; mem_rf_we = 1'b1;
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "reg0");
        idle_in();

        // div, then mflo waits until the cycle after DONE
        id_mdu_op = MDU_DIV;
        step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "div_start");
        id_mdu_op = MDU_NONE; id_reads_hilo = 1'b1;
        for (int i = 0; i < 33; i++) step(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, "mflo_hold");
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "mflo_go");
        idle_in();

        // mult held behind a div, launched the cycle after DONE
        id_mdu_op = MDU_DIV;
        step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "div2_start");
        id_mdu_op = MDU_MUL;
        for (int i = 0; i < 33; i++) step(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, "mult_hold");
        step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "mult_start");
        id_mdu_op = MDU_NONE;
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "mult_busy");
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "mult_done");

        // load-use blocks a launch from IDLE; reserved op never launches
        id_mdu_op = MDU_MUL; id_uses_rs = 1'b1; id_rs_addr = 5'd3;
        exe_rf_we = 1'b1; exe_rf_waddr = 5'd3; exe_is_load = 1'b1;
        step(1'b1, FW ? FWD_EXE : FWD_RF, 2'b00, 1'b0, 1'b0, "lu_blocks_start");
        idle_in(); id_mdu_op = 2'b11;
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "op_reserved");

        // reset in the middle of a div
        id_mdu_op = MDU_DIV;
        step(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, "div3_start");
        id_mdu_op = MDU_NONE;
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "div3_busy");
        id_reads_hilo = 1'b1;
        reset = 1'b1;
        #1;
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "reset_abort");
        reset = 1'b0;
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "post_reset");
        idle_in();
        step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "post_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
